// File: rtl/fp_add_sequencer.sv
// Host-side initiator for the serial-load FP adder: takes an operand pair, loads A then B,
// waits for the finished pulse and returns the result. Optional WAIT watchdog: FP_ADD_SEQ_TIMEOUT_EN.
module fp_add_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_error,
    output logic        add_start,
    output logic [31:0] add_data,
    input  logic        add_finished,
    input  logic [31:0] add_result,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    // Both handshakes transfer on a rising edge where valid and ready are high together;
    // valid and ready decode from registered state only, so neither depends on the other side.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_data_q, res_data_d;

`ifdef FP_ADD_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_error_q, res_error_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > CNT_W);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
`ifdef FP_ADD_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
            res_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_data_q  <= res_data_d;
`ifdef FP_ADD_SEQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
            res_error_q <= res_error_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_data_d  = res_data_q;
`ifdef FP_ADD_SEQ_TIMEOUT_EN
        cnt_d       = cnt_q;
        res_error_d = res_error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
`ifdef FP_ADD_SEQ_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef FP_ADD_SEQ_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
                // A finish on the timeout cycle still returns the real result.
                if (add_finished) begin
                    res_data_d  = add_result;
                    res_error_d = 1'b0;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d  = QNAN;
                    res_error_d = 1'b1;
                    state_d     = S_RESP;
                end
`else
                if (add_finished) begin
                    res_data_d = add_result;
                    state_d    = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        add_start = (state_q == S_LOAD_A);
        res_valid = (state_q == S_RESP);
        res_data  = res_data_q;
        dbg_state = state_q;
        add_data  = '0;
        if (state_q == S_LOAD_A) add_data = a_q;
        if (state_q == S_LOAD_B) add_data = b_q;
`ifdef FP_ADD_SEQ_TIMEOUT_EN
        res_error = res_error_q;
`else
        res_error = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: the adder side is driven by hand from each scenario task.
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_error;
    logic        add_start;
    logic [31:0] add_data;
    logic        add_finished;
    logic [31:0] add_result;
    logic        busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fp_add_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
        .add_start(add_start), .add_data(add_data),
        .add_finished(add_finished), .add_result(add_result),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IDLE: accept a pair, step through both load cycles, return in the first WAIT cycle.
    task automatic send_op(input logic [31:0] a, input logic [31:0] b);
        op_a = a; op_b = b; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic finish_op(input logic [31:0] r);
        add_finished = 1'b1; add_result = r;
        tick();
        add_finished = 1'b0;
    endtask

    task automatic handoff();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
        res_ready = 1'b0; add_finished = 1'b0; add_result = '0;
        tick(); tick();
        checks++;
        if ({op_ready, res_valid, res_error, add_start, busy} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 10000", {op_ready, res_valid, res_error, add_start, busy});
        end
        checks++;
        if (add_data !== 32'h0 || res_data !== 32'h0) begin
            errors++; $display("FAIL reset_data add_data %h res_data %h exp 0", add_data, res_data);
        end
        checks++;
        if (dbg_state !== 3'd0) begin
            errors++; $display("FAIL reset_state got %0d exp 0", dbg_state);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        checks++;
        if (op_ready !== 1'b1) begin
            errors++; $display("FAIL nom_op_ready got %b exp 1", op_ready);
        end
        op_a = 32'h3F80_0000; op_b = 32'h4000_0000; op_valid = 1'b1;
        tick();
        op_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
        checks++;
        if (add_start !== 1'b1 || add_data !== 32'h3F80_0000 || busy !== 1'b1 || op_ready !== 1'b0) begin
            errors++; $display("FAIL nom_load_a start %b data %h busy %b exp 1 3f800000 1", add_start, add_data, busy);
        end
        tick();
        checks++;
        if (add_start !== 1'b0 || add_data !== 32'h4000_0000) begin
            errors++; $display("FAIL nom_load_b start %b data %h exp 0 40000000", add_start, add_data);
        end
        tick();
        checks++;
        if (add_data !== 32'h0 || res_valid !== 1'b0 || add_start !== 1'b0) begin
            errors++; $display("FAIL nom_wait data %h res_valid %b exp 0 0", add_data, res_valid);
        end
        tick(); tick(); tick();
        finish_op(32'h4040_0000);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h4040_0000 || res_error !== 1'b0) begin
            errors++; $display("FAIL nom_result valid %b data %h err %b exp 1 40400000 0", res_valid, res_data, res_error);
        end
        handoff();
        checks++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL nom_handoff op_ready %b res_valid %b exp 1 0", op_ready, res_valid);
        end
    endtask

    task automatic test_backpressure();
        send_op(32'h3F80_0000, 32'h3F80_0000);
        finish_op(32'h4000_0000);
        op_a = 32'h4120_0000; op_b = 32'h4120_0000; op_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== 32'h4000_0000 || op_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc %0d valid %b data %h op_ready %b exp 1 40000000 0", i, res_valid, res_data, op_ready);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0; op_valid = 1'b0;
        checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release op_ready %b busy %b exp 1 0", op_ready, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL bp_no_accept busy %b exp 0", busy);
        end
    endtask

    task automatic test_timeout();
`ifdef FP_ADD_SEQ_TIMEOUT_EN
        send_op(32'h3F80_0000, 32'h4000_0000);
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_wait8 res_valid %b busy %b exp 0 1", res_valid, busy);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h7FC0_0000 || res_error !== 1'b1) begin
            errors++; $display("FAIL to_expire valid %b data %h err %b exp 1 7fc00000 1", res_valid, res_data, res_error);
        end
        handoff();
        send_op(32'h3F80_0000, 32'h4000_0000);
        for (int i = 0; i < 7; i++) tick();
        finish_op(32'h4040_0000);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h4040_0000 || res_error !== 1'b0) begin
            errors++; $display("FAIL to_race valid %b data %h err %b exp 1 40400000 0", res_valid, res_data, res_error);
        end
        handoff();
`else
        send_op(32'h3F80_0000, 32'h4000_0000);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL nowdt_wait res_valid %b busy %b exp 0 1", res_valid, busy);
        end
        finish_op(32'h4040_0000);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h4040_0000 || res_error !== 1'b0) begin
            errors++; $display("FAIL nowdt_result valid %b data %h err %b exp 1 40400000 0", res_valid, res_data, res_error);
        end
        handoff();
`endif
    endtask

    task automatic test_spurious();
        op_a = 32'h4000_0000; op_b = 32'hC0E0_0000; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        add_finished = 1'b1; add_result = 32'h1111_1111;
        tick();
        add_finished = 1'b0; add_result = 32'h0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL spur_ignored res_valid %b busy %b exp 0 1", res_valid, busy);
        end
        tick(); tick();
        finish_op(32'hC0A0_0000);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'hC0A0_0000 || res_error !== 1'b0) begin
            errors++; $display("FAIL spur_result valid %b data %h err %b exp 1 c0a00000 0", res_valid, res_data, res_error);
        end
        handoff();
    endtask

    task automatic test_reset_mid_op();
        send_op(32'h4080_0000, 32'h4080_0000);
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({op_ready, res_valid, res_error, add_start, busy} !== 5'b10000 || dbg_state !== 3'd0) begin
            errors++; $display("FAIL rst_mid_ctrl got %b state %0d exp 10000 0", {op_ready, res_valid, res_error, add_start, busy}, dbg_state);
        end
        checks++;
        if (add_data !== 32'h0 || res_data !== 32'h0) begin
            errors++; $display("FAIL rst_mid_data add_data %h res_data %h exp 0", add_data, res_data);
        end
        add_finished = 1'b1; add_result = 32'h4100_0000;
        tick();
        add_finished = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 32'h0) begin
            errors++; $display("FAIL rst_mid_held busy %b valid %b data %h exp 0 0 0", busy, res_valid, res_data);
        end
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_dropped res_valid %b busy %b exp 0 0", res_valid, busy);
        end
        send_op(32'h4040_0000, 32'h3F80_0000);
        finish_op(32'h4080_0000);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h4080_0000 || res_error !== 1'b0) begin
            errors++; $display("FAIL rst_mid_next valid %b data %h err %b exp 1 40800000 0", res_valid, res_data, res_error);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[4];
        logic [31:0] vb[4];
        logic [31:0] vr[4];
        logic [31:0] exp;
        va = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'hBF80_0000};
        vb = '{32'h3F80_0000, 32'h4040_0000, 32'h4080_0000, 32'hBF80_0000};
        vr = '{32'h4000_0000, 32'h40A0_0000, 32'h40E0_0000, 32'hC000_0000};
        res_ready = 1'b1;
        op_a = va[0]; op_b = vb[0]; op_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_q.push_back(vr[i]);
            checks++;
            if (add_start !== 1'b1 || add_data !== va[i]) begin
                errors++; $display("FAIL b2b_load_a %0d start %b data %h exp 1 %h", i, add_start, add_data, va[i]);
            end
            if (i < 3) begin
                op_a = va[i+1]; op_b = vb[i+1];
            end else begin
                op_valid = 1'b0;
            end
            tick();
            checks++;
            if (add_data !== vb[i]) begin
                errors++; $display("FAIL b2b_load_b %0d data %h exp %h", i, add_data, vb[i]);
            end
            tick();
            finish_op(vr[i]);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp) begin
                errors++; $display("FAIL b2b_result %0d valid %b data %h exp 1 %h", i, res_valid, res_data, exp);
            end
            tick();
            checks++;
            if (op_ready !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL b2b_gap %0d op_ready %b busy %b exp 1 0", i, op_ready, busy);
            end
        end
        res_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain left %0d exp 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_spurious();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
